// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency memory reads,
// and buffers tagged returns in a small FIFO feeding decode over valid/ready.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         is_jump,
    input  logic [7:0]                   jump_addr,
    output logic                         imem_req,
    output logic [7:0]                   imem_addr,
    input  logic [31:0]                  imem_rdata,
    output logic [31:0]                  inst,
    output logic [7:0]                   inst_pc,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    fetch_pc;
    logic [7:0]    req_pc;
    logic          inflight;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] occ;
    logic [31:0]   buf_inst [DEPTH];
    logic [7:0]    buf_pc   [DEPTH];
    logic          push;
    logic          pop;
    logic [CW:0]   credit;
    logic          unused_jump_bits;

    assign unused_jump_bits = ^jump_addr[1:0];

    assign inst_valid = (occ != '0);
    assign count      = occ;
    assign pop        = inst_valid & inst_ready;
    assign push       = inflight & ~is_jump;

    // Slots committed after this edge; a request only goes out if its response will fit.
    assign credit    = (CW+1)'(occ) + (CW+1)'(inflight) - (CW+1)'(pop);
    assign imem_req  = ~is_jump & (credit < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;

    assign inst    = inst_valid ? buf_inst[rd_ptr] : NOP_INST;
    assign inst_pc = inst_valid ? buf_pc[rd_ptr]   : 8'h00;

    // Fetch PC, in-flight tracking and FIFO bookkeeping; a redirect overrides everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
        end else if (is_jump) begin
            fetch_pc <= {jump_addr[7:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc <= fetch_pc + 8'd4;
                req_pc   <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: ;
            endcase
        end
    end

    // Entry storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed cycle checks plus a scoreboard of expected decode pops.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst, is_jump, inst_ready;
    logic [7:0]  jump_addr;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata, inst;
    logic [7:0]  inst_pc;
    logic        inst_valid;
    logic [2:0]  count;

    logic        w_jump = 1'b0;
    logic        w_ready = 1'b1;
    logic [7:0]  w_jaddr = 8'h00;
    logic        w_req, w_valid;
    logic [7:0]  w_addr, w_pc;
    logic [31:0] w_rdata, w_inst;
    logic [2:0]  w_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk(clk), .rst(rst), .is_jump(is_jump), .jump_addr(jump_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .count(count)
    );

    fetch_queue #(.RESET_PC(8'hF8)) dut_w (
        .clk(clk), .rst(rst), .is_jump(w_jump), .jump_addr(w_jaddr),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .inst(w_inst), .inst_pc(w_pc), .inst_valid(w_valid),
        .inst_ready(w_ready), .count(w_count)
    );

    // Memory returns addr*16 one cycle after the request.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? {20'h0, imem_addr, 4'h0} : 32'hDEADBEEF;
        w_rdata    <= w_req    ? {20'h0, w_addr, 4'h0}    : 32'hDEADBEEF;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every accepted head must match the next expected entry.
    always @(negedge clk) begin
        if (rst && inst_valid && inst_ready && !is_jump) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got pc 0x%0h, want no pop", inst_pc);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_pc", 32'(inst_pc), 32'(mon_e.pc));
                chk("sb_inst", inst, mon_e.data);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sb.delete();
        rst = 1'b0; is_jump = 1'b0; jump_addr = 8'h00; inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic expect_run(input logic [7:0] start, input int n);
        logic [7:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            sb.push_back({pc, 20'h0, pc, 4'h0});
            pc = pc + 8'd4;
        end
    endtask

    task automatic drain(input string name, input bit alternate);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            inst_ready = alternate ? ~inst_ready : 1'b1;
            @(negedge clk);
            chk({name, "_count_le_4"}, 32'(count <= 3'd4), 32'd1);
            next_cycle();
            k++;
        end
        inst_ready = 1'b0;
        chk({name, "_drain_in_time"}, 32'(k < 300), 32'd1);
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] wa;
        int nreq;
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wa;
        int nreq;

        // Reset state, then a free-running stream with decode always ready.
        rst = 1'b0; is_jump = 1'b0; jump_addr = 8'h00; inst_ready = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_inst", inst, 32'h00000013);
        chk("rst_pc", 32'(inst_pc), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_addr", 32'(imem_addr), 32'h00);
        chk("rst_w_addr", 32'(w_addr), 32'hF8);
        @(posedge clk);
        #1 rst = 1'b1;
        expect_run(8'h00, 10);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("t1_addr", 32'(imem_addr), 32'(8'(4 * k)));
            chk("t1_valid", 32'(inst_valid), 32'(k >= 2));
            wa = 8'hF8 + 8'(4 * k);
            chk("t4_wrap_addr", 32'(w_addr), 32'(wa));
            if (k >= 2) begin
                wa = 8'hF8 + 8'(4 * (k - 2));
                chk("t4_wrap_pc", 32'(w_pc), 32'(wa));
                chk("t4_wrap_inst", w_inst, {20'h0, wa, 4'h0});
            end
            next_cycle();
        end
        inst_ready = 1'b0;
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Decode stalled from reset: exactly DEPTH requests, then resume.
        do_reset();
        nreq = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (imem_req) begin
                chk("t2_addr", 32'(imem_addr), 32'(8'(4 * nreq)));
                nreq++;
            end
            next_cycle();
        end
        chk("t2_nreq", 32'(nreq), 32'd4);
        @(negedge clk);
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_req_held", 32'(imem_req), 32'd0);
        next_cycle();
        expect_run(8'h00, 8);
        inst_ready = 1'b1;
        @(negedge clk);
        chk("t2_resume_req", 32'(imem_req), 32'd1);
        chk("t2_resume_addr", 32'(imem_addr), 32'h10);
        next_cycle();
        drain("t2", 1'b0);

        // Redirect in cycle 6 to 0x43 (aligned to 0x40).
        do_reset();
        inst_ready = 1'b1;
        expect_run(8'h00, 4);
        expect_run(8'h40, 4);
        repeat (6) next_cycle();
        is_jump = 1'b1; jump_addr = 8'h43;
        @(negedge clk);
        chk("t3_jump_req", 32'(imem_req), 32'd0);
        next_cycle();
        is_jump = 1'b0; jump_addr = 8'h00;
        @(negedge clk);
        chk("t3_j1_count", 32'(count), 32'd0);
        chk("t3_j1_valid", 32'(inst_valid), 32'd0);
        chk("t3_j1_req", 32'(imem_req), 32'd1);
        chk("t3_j1_addr", 32'(imem_addr), 32'h40);
        next_cycle();
        @(negedge clk);
        chk("t3_j2_valid", 32'(inst_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t3_j3_valid", 32'(inst_valid), 32'd1);
        chk("t3_j3_pc", 32'(inst_pc), 32'h40);
        next_cycle();
        drain("t3", 1'b0);

        // Decode ready toggling every cycle.
        do_reset();
        expect_run(8'h00, 12);
        drain("t5", 1'b1);

        // Asynchronous reset with three entries buffered.
        do_reset();
        repeat (4) next_cycle();
        @(negedge clk);
        chk("t6_count_pre", 32'(count), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_valid", 32'(inst_valid), 32'd0);
        chk("t6_async_count", 32'(count), 32'd0);
        chk("t6_async_inst", inst, 32'h00000013);
        chk("t6_async_pc", 32'(inst_pc), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_restart_req", 32'(imem_req), 32'd1);
        chk("t6_restart_addr", 32'(imem_addr), 32'h00);
        next_cycle();
        expect_run(8'h00, 3);
        drain("t6", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end placed directly upstream of decode.
- Owns the fetch PC and issues requests to a synchronous instruction memory with a fixed 1-cycle read latency.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Flushes all buffered and in-flight instructions on a jump redirect.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 8'h00, fetch PC loaded at reset.
- NOP_INST, 32'h00000013, value driven on inst while the queue is empty.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- is_jump  input  1  redirect request from execute, sampled at the clock edge.
- jump_addr  input  8  redirect target; bits [1:0] ignored and forced to 0.
- imem_req  output  1  read request this cycle; combinational.
- imem_addr  output  8  read byte address; equals fetch_pc.
- imem_rdata  input  32  read data, valid in the cycle after imem_req=1.
- inst  output  32  head instruction; NOP_INST when empty.
- inst_pc  output  8  PC of the head instruction; 0 when empty.
- inst_valid  output  1  queue is non-empty.
- inst_ready  input  1  decode accepts the head this cycle.
- count  output  3  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, queue empty, count=0, inflight=0, inst_valid=0, inst=NOP_INST, inst_pc=0. imem_req follows the combinational rule below.
  - A reset asserted mid-stream drops all entries and the in-flight response immediately.
- Internal state:
  - fetch_pc[7:0]
  - inflight flag: a request was issued last cycle.
  - Circular buffer of {inst, pc} entries with read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus count.
- Pop: pop = inst_valid & inst_ready. At the edge, the head advances and count decrements.
- Request rule (combinational): imem_req = ~is_jump & (count + inflight - pop < DEPTH).
  - The credit check guarantees every in-flight response has a free slot; the FIFO never overflows and there is no backpressure toward memory.
- On a request:
  - imem_addr = fetch_pc.
  - At the edge, fetch_pc <= fetch_pc + 4, modulo 256 (8'hFC wraps to 8'h00).
  - inflight <= 1, and the PC of the request is saved in a register for tagging.
  - With no request, inflight <= 0 and fetch_pc holds.
- Push: in any cycle with inflight=1 and is_jump=0, {imem_rdata, saved pc} is written at the tail at the edge and count increments.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - A pop from an empty queue is impossible because inst_valid=0.
  - A push into a full queue is impossible by the credit rule.
- Redirect: when is_jump=1 at an edge, it has priority over push, pop and request:
  - count <= 0 and pointers reset.
  - inflight <= 0, so a response arriving this cycle is discarded.
  - fetch_pc <= {jump_addr[7:2], 2'b00}.
  - imem_req is 0 during the jump cycle.
  - The head may still be shown during the jump cycle, but decode must not rely on it.
- Outputs inst, inst_pc and inst_valid are registered-state derived: head of the FIFO, no combinational path from imem_rdata.
- Latency:
  - Request in cycle N, data in cycle N+1, visible at the head in cycle N+2.
  - After reset release: first request in cycle 0 (addr RESET_PC), inst_valid=1 in cycle 2.
  - Jump asserted in cycle J: request at the target in J+1, inst_valid=1 with inst_pc=target in J+3.
- Throughput: with inst_ready held at 1 and DEPTH>=2, one instruction per cycle is delivered in steady state.
- With inst_ready=0: the queue fills to DEPTH, and imem_req stays 0 while count + inflight = DEPTH.

Test Plan:
- Reset then inst_ready=1, memory returns addr*16 as data.
  - Required: imem_addr sequence 0x00,0x04,0x08…; inst_valid first rises in cycle 2.
  - Required: inst_pc 0x00,0x04,… and inst 0x00,0x40,0x80…, one per cycle with no bubbles.
- inst_ready=0 from reset.
  - Required: exactly 4 requests (0x00–0x0C), then imem_req=0; count settles at 4.
  - Then inst_ready=1: requests resume at 0x10 in the same cycle as the first pop; order is preserved.
- Steady stream with is_jump=1, jump_addr=8'h43 in cycle J.
  - Required: count=0 and inst_valid=0 in J+1; the response arriving in J is dropped.
  - Required: imem_addr=0x40 in J+1; inst_pc=0x40 in J+3.
- Start at RESET_PC=8'hF8 with inst_ready=1.
  - Required: addresses 0xF8,0xFC,0x00,0x04; inst_pc wraps identically.
- Alternate inst_ready 1/0 every cycle.
  - Required: no lost or duplicated instruction; count never exceeds 4; pushes and pops coincide without count change.
- Assert rst=0 asynchronously mid-stream with count=3.
  - Required: inst_valid=0, count=0, inst=32'h00000013 immediately, before the next clock.
  - Required: after release, fetch restarts at RESET_PC.
